// File: rtl/ps_setpoint_framer.sv
// ps_setpoint_framer: captures fixed-length setpoint frames from a no-backpressure
// AXI stream into a double-buffered bank, validates frame length, and forwards
// complete frames to the power-supply link as one header word plus the setpoints.
// Also provides registered CPU readback of the last accepted frame and
// saturating status counters.
module ps_setpoint_framer #(
  parameter int RESULT_COUNT       = 24,
  parameter int FLOAT_WIDTH        = 32,
  parameter int DBUS_WIDTH         = 32,
  parameter int RESULT_COUNT_WIDTH = (RESULT_COUNT == 1) ? 1 : $clog2(RESULT_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          SETPOINT_TVALID,
  input  logic                          SETPOINT_TLAST,
  input  logic [FLOAT_WIDTH-1:0]        SETPOINT_TDATA,
  output logic                          LINK_TVALID,
  input  logic                          LINK_TREADY,
  output logic                          LINK_TLAST,
  output logic [FLOAT_WIDTH-1:0]        LINK_TDATA,
  input  logic [RESULT_COUNT_WIDTH-1:0] readAddress,
  output logic [DBUS_WIDTH-1:0]         readData,
  output logic [15:0]                   framesSent,
  output logic [15:0]                   badFrames,
  output logic [15:0]                   droppedFrames
);

  // The write index must be able to hold RESULT_COUNT itself (the "full" marker).
  localparam int WR_W = $clog2(RESULT_COUNT + 1);
  localparam logic [WR_W-1:0] WR_FULL = WR_W'(RESULT_COUNT);
  localparam logic [WR_W-1:0] WR_LAST = WR_W'(RESULT_COUNT - 1);
  localparam logic [RESULT_COUNT_WIDTH-1:0] RD_LAST = RESULT_COUNT_WIDTH'(RESULT_COUNT - 1);
  localparam logic [RESULT_COUNT_WIDTH:0] RD_LIMIT = (RESULT_COUNT_WIDTH + 1)'(RESULT_COUNT);

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_HEADER = 2'd1,
    TX_DATA   = 2'd2
  } tx_state_e;

  // Saturating 16-bit increment for the status counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [FLOAT_WIDTH-1:0]        bank_q [2][RESULT_COUNT];
  logic [WR_W-1:0]               wr_idx_q, wr_idx_d;
  logic                          overflow_q, overflow_d;
  logic                          tx_bank_q, tx_bank_d;
  logic [7:0]                    seq_q, seq_d;
  tx_state_e                     state_q, state_d;
  logic [RESULT_COUNT_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [15:0]                   sent_q, sent_d;
  logic [15:0]                   bad_q, bad_d;
  logic [15:0]                   drop_q, drop_d;
  logic [DBUS_WIDTH-1:0]         rd_data_q, rd_data_d;
  logic                          have_frame_q, have_frame_d;
  logic                          wr_en_s, good_s, bad_s, last_fire_s, accept_s;
  logic                          link_valid_s, link_last_s;
  logic [FLOAT_WIDTH-1:0]        link_data_s;

  // Next-state logic: capture indexing, frame judgement, TX FSM, counters, readback.
  always_comb begin
    wr_idx_d     = wr_idx_q;
    overflow_d   = overflow_q;
    tx_bank_d    = tx_bank_q;
    seq_d        = seq_q;
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    sent_d       = sent_q;
    bad_d        = bad_q;
    drop_d       = drop_q;
    rd_data_d    = '0;
    have_frame_d = have_frame_q;
    wr_en_s      = 1'b0;
    good_s       = 1'b0;
    bad_s        = 1'b0;
    last_fire_s  = (state_q == TX_DATA) && LINK_TREADY && (rd_idx_q == RD_LAST);

    // Capture side: there is no back pressure, so every valid word is judged here.
    if (SETPOINT_TVALID) begin
      wr_en_s = (wr_idx_q < WR_FULL);
      if (SETPOINT_TLAST) begin
        good_s     = (wr_idx_q == WR_LAST) && !overflow_q;
        bad_s      = !good_s;
        wr_idx_d   = '0;
        overflow_d = 1'b0;
      end else if (wr_idx_q < WR_FULL) begin
        wr_idx_d = wr_idx_q + WR_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      wr_idx_d = wr_idx_q;
    end

    // A good frame can only be handed over when the transmit bank is free.
    accept_s = good_s && ((state_q == TX_IDLE) || last_fire_s);

    // Transmit FSM: advances only on a completed handshake.
    case (state_q)
      TX_IDLE: begin
        state_d = TX_IDLE;
      end
      TX_HEADER: begin
        if (LINK_TREADY) begin
          state_d  = TX_DATA;
          rd_idx_d = '0;
        end else begin
          state_d = TX_HEADER;
        end
      end
      TX_DATA: begin
        if (LINK_TREADY) begin
          if (rd_idx_q == RD_LAST) begin
            state_d  = TX_IDLE;
            rd_idx_d = '0;
            sent_d   = sat_inc(sent_q);
          end else begin
            rd_idx_d = rd_idx_q + RESULT_COUNT_WIDTH'(1);
          end
        end else begin
          state_d = TX_DATA;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase

    // Bank swap overrides the FSM's return to idle when a frame is waiting.
    if (accept_s) begin
      state_d      = TX_HEADER;
      tx_bank_d    = ~tx_bank_q;
      seq_d        = seq_q + 8'd1;
      have_frame_d = 1'b1;
    end else if (good_s) begin
      drop_d = sat_inc(drop_q);
    end else begin
      drop_d = drop_q;
    end

    if (bad_s) begin
      bad_d = sat_inc(bad_q);
    end else begin
      bad_d = bad_q;
    end

    // Readback comes from the bank currently owned by the transmitter.
    if (have_frame_q && ({1'b0, readAddress} < RD_LIMIT)) begin
      rd_data_d = DBUS_WIDTH'(bank_q[tx_bank_q][readAddress]);
    end else begin
      rd_data_d = '0;
    end

    // Link outputs decode straight from registered state so they hold under stall.
    link_valid_s = 1'b0;
    link_last_s  = 1'b0;
    link_data_s  = '0;
    case (state_q)
      TX_HEADER: begin
        link_valid_s = 1'b1;
        link_data_s  = FLOAT_WIDTH'({8'hA5, seq_q, 16'(RESULT_COUNT)});
      end
      TX_DATA: begin
        link_valid_s = 1'b1;
        link_last_s  = (rd_idx_q == RD_LAST);
        link_data_s  = bank_q[tx_bank_q][rd_idx_q];
      end
      default: begin
        link_valid_s = 1'b0;
      end
    endcase
  end

  // Setpoint storage: written into the capture bank, which is always the non-TX bank.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      bank_q[~tx_bank_q][wr_idx_q[RESULT_COUNT_WIDTH-1:0]] <= SETPOINT_TDATA;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q     <= '0;
      overflow_q   <= 1'b0;
      tx_bank_q    <= 1'b0;
      seq_q        <= 8'd0;
      state_q      <= TX_IDLE;
      rd_idx_q     <= '0;
      sent_q       <= 16'd0;
      bad_q        <= 16'd0;
      drop_q       <= 16'd0;
      rd_data_q    <= '0;
      have_frame_q <= 1'b0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      overflow_q   <= overflow_d;
      tx_bank_q    <= tx_bank_d;
      seq_q        <= seq_d;
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      sent_q       <= sent_d;
      bad_q        <= bad_d;
      drop_q       <= drop_d;
      rd_data_q    <= rd_data_d;
      have_frame_q <= have_frame_d;
    end
  end

  assign LINK_TVALID   = link_valid_s;
  assign LINK_TLAST    = link_last_s;
  assign LINK_TDATA    = link_data_s;
  assign readData      = rd_data_q;
  assign framesSent    = sent_q;
  assign badFrames     = bad_q;
  assign droppedFrames = drop_q;

endmodule

// File: tb/tb_ps_setpoint_framer.sv
// Bench for ps_setpoint_framer: scoreboard of expected link words, a readback
// vector table, and hand-written sequences for stall, back-to-back, reset and
// counter saturation corners.
module tb_ps_setpoint_framer;

  localparam int RC = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SETPOINT_TVALID, SETPOINT_TLAST;
  logic [31:0] SETPOINT_TDATA;
  logic        LINK_TVALID, LINK_TREADY, LINK_TLAST;
  logic [31:0] LINK_TDATA;
  logic [4:0]  readAddress;
  logic [31:0] readData;
  logic [15:0] framesSent, badFrames, droppedFrames;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  logic [7:0]  exp_seq;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } rb_vec_t;
  rb_vec_t rb_vec [6];

  always #5 clk = ~clk;

  ps_setpoint_framer dut (
    .clk(clk), .rst_n(rst_n),
    .SETPOINT_TVALID(SETPOINT_TVALID), .SETPOINT_TLAST(SETPOINT_TLAST),
    .SETPOINT_TDATA(SETPOINT_TDATA),
    .LINK_TVALID(LINK_TVALID), .LINK_TREADY(LINK_TREADY), .LINK_TLAST(LINK_TLAST),
    .LINK_TDATA(LINK_TDATA),
    .readAddress(readAddress), .readData(readData),
    .framesSent(framesSent), .badFrames(badFrames), .droppedFrames(droppedFrames)
  );

  // IEEE single encoding of a small positive integer (1..255).
  function automatic logic [31:0] flt(input int n);
    int e;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'(n << (23 - e))};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic l, input logic [31:0] d, input logic r);
    SETPOINT_TVALID = v;
    SETPOINT_TLAST  = l;
    SETPOINT_TDATA  = d;
    LINK_TREADY     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int base);
    exp_seq = exp_seq + 8'd1;
    exp_q.push_back({1'b0, 8'hA5, exp_seq, 16'd24});
    for (int k = 0; k < RC; k++) exp_q.push_back({(k == RC - 1), flt(base + k + 1)});
  endtask

  task automatic send_frame(input int base, input int n, input bit push, input logic r);
    for (int k = 0; k < n; k++) begin
      if (push && (k == n - 1)) push_frame(base);
      cyc(1'b1, (k == n - 1), flt(base + k + 1), r);
    end
    SETPOINT_TVALID = 1'b0;
    SETPOINT_TLAST  = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((i < 300) && ((exp_q.size() != 0) || LINK_TVALID)) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      i++;
    end
    check("link_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tvalid"}, 64'(LINK_TVALID), 64'd0);
    check({tag, "_tlast"}, 64'(LINK_TLAST), 64'd0);
    check({tag, "_tdata"}, 64'(LINK_TDATA), 64'd0);
    check({tag, "_readData"}, 64'(readData), 64'd0);
    check({tag, "_framesSent"}, 64'(framesSent), 64'd0);
    check({tag, "_badFrames"}, 64'(badFrames), 64'd0);
    check({tag, "_droppedFrames"}, 64'(droppedFrames), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_seq = 8'd0;
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  // Scoreboard: every handshake on the link must match the next expected word.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && LINK_TVALID && LINK_TREADY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL link_unexpected: got %h expected no word", {LINK_TLAST, LINK_TDATA});
      end else begin
        e = exp_q.pop_front();
        check("link_word", 64'({LINK_TLAST, LINK_TDATA}), 64'(e));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [33:0] hold;
    rb_vec[0] = '{5'd5,  32'h40C00000};
    rb_vec[1] = '{5'd0,  32'h3F800000};
    rb_vec[2] = '{5'd1,  32'h40000000};
    rb_vec[3] = '{5'd23, 32'h41C00000};
    rb_vec[4] = '{5'd24, 32'h00000000};
    rb_vec[5] = '{5'd31, 32'h00000000};

    rst_n = 1'b0;
    SETPOINT_TVALID = 1'b0; SETPOINT_TLAST = 1'b0; SETPOINT_TDATA = 32'd0;
    LINK_TREADY = 1'b1; readAddress = 5'd0;
    exp_seq = 8'd0;
    #1;
    check_zero("reset");
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("pre_frame_readData", 64'(readData), 64'd0);

    // Basic frame 1.0..24.0
    send_frame(0, RC, 1'b1, 1'b1);
    check("hdr_latency_valid", 64'(LINK_TVALID), 64'd1);
    check("hdr_first", 64'(LINK_TDATA), 64'hA5010018);
    wait_idle();
    check("framesSent_1", 64'(framesSent), 64'd1);
    for (int i = 0; i < 6; i++) begin
      readAddress = rb_vec[i].addr;
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      check("readback", 64'(readData), 64'(rb_vec[i].exp));
    end

    // Short and long frames are rejected; the next good frame carries seq 1
    do_reset();
    send_frame(50, 23, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    send_frame(50, 25, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("badFrames_2", 64'(badFrames), 64'd2);
    check("bad_no_link", 64'(LINK_TVALID), 64'd0);
    send_frame(100, RC, 1'b1, 1'b1);
    check("hdr_after_bad", 64'(LINK_TDATA), 64'hA5010018);
    wait_idle();
    check("framesSent_after_bad", 64'(framesSent), 64'd1);

    // Good TLAST coincides with final link word: no idle cycle between frames
    send_frame(10, RC, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    send_frame(40, RC, 1'b1, 1'b1);
    check("b2b_valid", 64'(LINK_TVALID), 64'd1);
    check("b2b_hdr", 64'(LINK_TDATA), 64'hA5030018);
    check("b2b_dropped", 64'(droppedFrames), 64'd0);
    wait_idle();
    check("framesSent_b2b", 64'(framesSent), 64'd3);

    // Ten-cycle stall mid-data; a second good frame completes during it
    send_frame(70, RC, 1'b1, 1'b1);
    hold = '0;
    for (int j = 0; j < 25; j++) begin
      if (j == 15) hold = {LINK_TVALID, LINK_TLAST, LINK_TDATA};
      else if (j > 15) check("stall_hold", 64'({LINK_TVALID, LINK_TLAST, LINK_TDATA}), 64'(hold));
      cyc((j >= 1), (j == 24), (j >= 1) ? flt(220 + j) : 32'd0, (j < 15));
    end
    SETPOINT_TVALID = 1'b0; SETPOINT_TLAST = 1'b0;
    check("stall_hold_end", 64'({LINK_TVALID, LINK_TLAST, LINK_TDATA}), 64'(hold));
    check("droppedFrames_1", 64'(droppedFrames), 64'd1);
    wait_idle();
    check("framesSent_stall", 64'(framesSent), 64'd4);
    check("droppedFrames_still_1", 64'(droppedFrames), 64'd1);

    // Reset during transmission and capture
    send_frame(130, RC, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, flt(160 + k + 1), 1'b1);
    SETPOINT_TVALID = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_seq = 8'd0;
    #1;
    check_zero("midreset");
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    for (int k = 10; k < RC; k++) cyc(1'b1, (k == RC - 1), flt(160 + k + 1), 1'b1);
    SETPOINT_TVALID = 1'b0; SETPOINT_TLAST = 1'b0;
    check("partial_bad", 64'(badFrames), 64'd1);
    check("partial_no_link", 64'(LINK_TVALID), 64'd0);
    send_frame(190, RC, 1'b1, 1'b1);
    check("hdr_after_reset", 64'(LINK_TDATA), 64'hA5010018);
    wait_idle();
    check("framesSent_after_reset", 64'(framesSent), 64'd1);

    // badFrames saturation
    do_reset();
    for (int i = 0; i < 65534; i++) cyc(1'b1, 1'b1, 32'd0, 1'b1);
    SETPOINT_TVALID = 1'b0; SETPOINT_TLAST = 1'b0;
    check("badFrames_FFFE", 64'(badFrames), 64'hFFFE);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'd0, 1'b1);
    SETPOINT_TVALID = 1'b0; SETPOINT_TLAST = 1'b0;
    check("badFrames_sat", 64'(badFrames), 64'hFFFF);
    cyc(1'b1, 1'b1, 32'd0, 1'b1);
    SETPOINT_TVALID = 1'b0; SETPOINT_TLAST = 1'b0;
    check("badFrames_sat_hold", 64'(badFrames), 64'hFFFF);
    check("sat_no_frames", 64'(framesSent), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
